bconv_datapath: RTL and testbench

//  Datapath/responder side of the binary-convolution controller protocol. Decodes the 3-bit

---
 rtl/bconv_pkg.sv | 42 ++++
 rtl/bconv_datapath_popcount.sv | 17 +
 rtl/bconv_datapath.sv | 139 +++++++++++++
 tb/tb_bconv_datapath.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bconv_pkg.sv
// Shared state codes and sequence rules for the binary-convolution datapath.
// BCONV_BIPOLAR_EN selects a signed 2*pop-DATA_W result instead of a raw popcount.
package bconv_pkg;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'b000,
    ST_READMEM  = 3'b001,
    ST_XNORS    = 3'b011,
    ST_COUNT1S  = 3'b010,
    ST_OUTPUTS  = 3'b110,
    ST_WRITEMEM = 3'b111,
    ST_DONE     = 3'b101,
    ST_SYSRESET = 3'b100
  } cstate_e;

`ifdef BCONV_BIPOLAR_EN
  localparam int BIPOLAR = 1;
`else
  localparam int BIPOLAR = 0;
`endif

  function automatic logic [2:0] succ(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      ST_WAIT:     n = ST_READMEM;
      ST_READMEM:  n = ST_XNORS;
      ST_XNORS:    n = ST_COUNT1S;
      ST_COUNT1S:  n = ST_OUTPUTS;
      ST_OUTPUTS:  n = ST_WRITEMEM;
      ST_WRITEMEM: n = ST_DONE;
      default:     n = ST_WAIT;
    endcase
    return n;
  endfunction

  function automatic logic legal(input logic [2:0] p,
                                 input logic [2:0] c);
    return (c == succ(p)) || (c == ST_SYSRESET) ||
           ((p == ST_WAIT) && (c == ST_WAIT));
  endfunction

endpackage

// File: rtl/bconv_datapath_popcount.sv
// Combinational population count of a DATA_W-bit word.
// Summation is left to synthesis to balance into an adder tree.
module bconv_popcount #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DATA_W; i++)
      cnt_o = cnt_o + CNT_W'(data_i[i]);
  end

endmodule

// File: rtl/bconv_datapath.sv
// Responder datapath for the binary-convolution controller: read, XNOR, popcount, write.
// BCONV_BIPOLAR_EN widens the count field to a signed CNT_W+1 bit value.
module bconv_datapath
  import bconv_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int NUM_WIN = 16,
  parameter int WR_BASE = 128,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  localparam int RES_W  = CNT_W + BIPOLAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cState,
  input  logic [DATA_W-1:0] weights,
  input  logic [CNT_W-1:0]  threshold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              result_bit,
  output logic [RES_W-1:0]  result_cnt,
  output logic              done,
  output logic              last_win,
  output logic              seq_err
);

  localparam int PAD = DATA_W - 1 - RES_W;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2:0]        prev_q;
  logic [DATA_W-1:0] xnor_q, xnor_d;
  logic [CNT_W-1:0]  pop_q, pop_d, pop_sum;
  logic [RES_W-1:0]  cnt_q, cnt_d, res_val;
  logic              bit_q, bit_d;
  logic              err_q, err_d;
  logic              s_rd, s_xn, s_c1, s_out;
  logic              s_wr, s_dn, s_sr;
  logic              is_last;

  always_comb begin
    s_rd  = 1'b0;
    s_xn  = 1'b0;
    s_c1  = 1'b0;
    s_out = 1'b0;
    s_wr  = 1'b0;
    s_dn  = 1'b0;
    s_sr  = 1'b0;
    case (cState)
      ST_READMEM:  s_rd  = 1'b1;
      ST_XNORS:    s_xn  = 1'b1;
      ST_COUNT1S:  s_c1  = 1'b1;
      ST_OUTPUTS:  s_out = 1'b1;
      ST_WRITEMEM: s_wr  = 1'b1;
      ST_DONE:     s_dn  = 1'b1;
      ST_SYSRESET: s_sr  = 1'b1;
      default:     ;
    endcase
  end

  bconv_popcount #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_pop (
    .data_i(xnor_q),
    .cnt_o (pop_sum)
  );

`ifdef BCONV_BIPOLAR_EN
  assign res_val = {pop_q, 1'b0} - RES_W'(DATA_W);
`else
  assign res_val = pop_q;
`endif

  assign is_last = (idx_q == ADDR_W'(NUM_WIN - 1));

  always_comb begin
    idx_d  = idx_q;
    xnor_d = xnor_q;
    pop_d  = pop_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    err_d  = err_q;
    if (!legal(prev_q, cState)) err_d = 1'b1;
    if (s_xn) xnor_d = ~(mem_rdata ^ weights);
    if (s_c1) pop_d = pop_sum;
    if (s_out) begin
      cnt_d = res_val;
      bit_d = (pop_q >= threshold);
    end
    if (s_dn) idx_d = is_last ? '0 : idx_q + ADDR_W'(1);
    // Sync clear wins over a violation seen in the same cycle
    if (s_sr) begin
      idx_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      prev_q <= ST_SYSRESET;
      xnor_q <= '0;
      pop_q  <= '0;
      cnt_q  <= '0;
      bit_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      prev_q <= cState;
      xnor_q <= xnor_d;
      pop_q  <= pop_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      err_q  <= err_d;
    end
  end

  assign mem_re   = s_rd & ~reset;
  assign mem_we   = s_wr & ~reset;
  assign done     = s_dn & ~reset;
  assign last_win = done & is_last;

  always_comb begin
    mem_addr = '0;
    if (mem_re)
      mem_addr = idx_q;
    else if (mem_we)
      mem_addr = idx_q + ADDR_W'(WR_BASE);
  end

  assign mem_wdata  = mem_we ? {bit_q, {PAD{1'b0}}, cnt_q} : '0;
  assign result_bit = bit_q;
  assign result_cnt = cnt_q;
  assign seq_err    = err_q;

endmodule

// File: tb/tb_bconv_datapath.sv
// Directed bench for bconv_datapath with a per-cycle reference model.
// Build with BCONV_BIPOLAR_EN to check the signed count variant.
module tb_bconv_datapath;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int NUM_WIN = 16;
  localparam int WR_BASE = 128;
  localparam int CNT_W   = 5;
`ifdef BCONV_BIPOLAR_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif
  localparam int RES_W = CNT_W + (BIP ? 1 : 0);

  localparam logic [2:0] WT = 3'b000, RD = 3'b001, XN = 3'b011;
  localparam logic [2:0] C1 = 3'b010, OU = 3'b110, WR = 3'b111;
  localparam logic [2:0] DN = 3'b101, SR = 3'b100;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        cState;
  logic [DATA_W-1:0] weights;
  logic [CNT_W-1:0]  threshold;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              result_bit;
  logic [RES_W-1:0]  result_cnt;
  logic              done;
  logic              last_win;
  logic              seq_err;

  bconv_datapath #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WIN(NUM_WIN),
    .WR_BASE(WR_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cState    (cState),
    .weights   (weights),
    .threshold (threshold),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .result_bit(result_bit),
    .result_cnt(result_cnt),
    .done      (done),
    .last_win  (last_win),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
    logic [2:0] ring [7];
    ring = '{WT, RD, XN, C1, OU, WR, DN};
    if (c == SR) return 1'b1;
    if (p == SR && c == WT) return 1'b1;
    if (p == WT && c == WT) return 1'b1;
    for (int i = 0; i < 7; i++)
      if (ring[i] == p && ring[(i + 1) % 7] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RES_W-1:0] exp_cnt(input int pop);
    if (BIP) return RES_W'(2 * pop - DATA_W);
    return RES_W'(pop);
  endfunction

  int               m_idx;
  logic [2:0]       m_prev;
  bit               m_err, m_valid, m_bit;
  logic [RES_W-1:0] m_cnt;
  int               ps;
  logic [15:0]      m_word, m_w, ew;
  int               pop;
  logic [7:0]       ea;
  logic [7:0]       last_wr_addr, last_rd_addr;
  logic [15:0]      last_wr_data;
  int               lw_count, lw_pass, pass_no;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_re", mem_re, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", result_cnt, 0);
      chk("rst_bit", result_bit, 0);
      chk("rst_err", seq_err, 0);
      m_idx = 0; m_prev = SR; m_err = 0;
      m_valid = 1; m_bit = 0; m_cnt = '0; ps = 0;
    end else begin
      ea = (cState == RD) ? 8'(m_idx) :
           (cState == WR) ? 8'(WR_BASE + m_idx) : 8'h00;
      chk("mem_re", mem_re, cState == RD);
      chk("mem_we", mem_we, cState == WR);
      chk("mem_addr", mem_addr, ea);
      chk("done", done, cState == DN);
      chk("last_win", last_win, cState == DN && m_idx == NUM_WIN - 1);
      chk("seq_err", seq_err, m_err);
      if (m_valid) begin
        chk("result_cnt", result_cnt, m_cnt);
        chk("result_bit", result_bit, m_bit);
        if (cState == WR) begin
          ew = '0;
          ew[15] = m_bit;
          ew[RES_W-1:0] = m_cnt;
          chk("mem_wdata", mem_wdata, ew);
        end
      end
      if (mem_we) begin
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (mem_re) last_rd_addr = mem_addr;
      if (last_win) begin
        lw_count++;
        lw_pass = pass_no + 1;
      end
      if (cState == SR) m_err = 0;
      else if (!legal(m_prev, cState)) m_err = 1;
      m_prev = cState;
      case (cState)
        RD: begin ps = 1; m_word = ram[m_idx]; end
        XN: begin ps = (ps == 1) ? 2 : 0; m_w = weights; end
        C1: ps = (ps == 2) ? 3 : 0;
        OU: begin
          if (ps == 3) begin
            pop = $countones(~(m_word ^ m_w));
            m_cnt = exp_cnt(pop);
            m_bit = (pop >= int'(threshold));
            m_valid = 1;
          end else m_valid = 0;
          ps = 0;
        end
        DN: begin m_idx = (m_idx + 1) % NUM_WIN; ps = 0; end
        SR: begin m_idx = 0; ps = 0; end
        default: ps = 0;
      endcase
    end
  end

  task automatic step(input logic [2:0] cs);
    @(posedge clk);
    #1;
    cState = cs;
  endtask

  task automatic run_pass();
    step(RD); step(XN); step(C1); step(OU);
    step(WR); step(DN); step(WT);
    pass_no++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    lw_count = 0; lw_pass = 0; pass_no = 0;
    reset = 1'b1; cState = WT;
    weights = '0; threshold = '0; mem_rdata = '0;
    step(WT); step(WT);
    reset = 1'b0;
    step(WT);

    // 1: F0F0 against all-ones weights, thr 8
    ram[0] = 16'hF0F0; weights = 16'hFFFF; threshold = 5'd8;
    run_pass();
    chk("t1_addr", last_wr_addr, 8'd128);
    chk("t1_wdata", last_wr_data, BIP ? 16'h8000 : 16'h8008);
    chk("t1_bit", result_bit, 1);

    // 2: exact match
    ram[1] = 16'hA5A5; weights = 16'hA5A5;
    run_pass();
    chk("t2_cnt", result_cnt, 16);
    chk("t2_wdata", last_wr_data, 16'h8010);

    // 3: full mismatch, thr 1 then thr 0
    ram[2] = 16'h5A5A; ram[3] = 16'h5A5A; threshold = 5'd1;
    run_pass();
    chk("t3_bit", result_bit, 0);
    chk("t3_wdata", last_wr_data, BIP ? 16'h0030 : 16'h0000);
    threshold = 5'd0;
    run_pass();
    chk("t3b_bit", result_bit, 1);
    chk("t3b_wdata", last_wr_data, BIP ? 16'h8030 : 16'h8000);

    // 7: half match gives zero bipolar count
    ram[4] = 16'hF0F0; weights = 16'hFFFF; threshold = 5'd8;
    run_pass();
    chk("t7_cnt", result_cnt, BIP ? 0 : 8);
    chk("t7_bit", result_bit, 1);

    // threshold above DATA_W never fires
    threshold = 5'd17; ram[5] = 16'hFFFF;
    run_pass();
    chk("thr_hi_bit", result_bit, 0);

    // 4: full frame
    step(SR); step(WT);
    weights = 16'h3C3C; threshold = 5'd9;
    for (int i = 0; i < NUM_WIN; i++)
      ram[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
    lw_count = 0; pass_no = 0;
    for (int i = 0; i < NUM_WIN; i++) run_pass();
    chk("t4_lw_count", lw_count, 1);
    chk("t4_lw_pass", lw_pass, 16);
    step(RD);
    #2;
    chk("t4_wrap_addr", mem_addr, 0);
    step(XN); step(C1); step(OU); step(WR); step(DN); step(WT);

    // 5: illegal jump sets a sticky error
    step(SR); step(WT); step(XN); step(C1);
    chk("t5_err_set", seq_err, 1);
    step(OU); step(WR); step(DN); step(WT);
    run_pass();
    chk("t5_err_hold", seq_err, 1);
    step(SR); step(WT);
    chk("t5_err_clr", seq_err, 0);
    run_pass();

    // 6: async reset mid-pass
    step(WT); step(XN); step(C1);
    reset = 1'b1;
    #2;
    chk("t6_cnt", result_cnt, 0);
    chk("t6_bit", result_bit, 0);
    chk("t6_err", seq_err, 0);
    step(WT);
    reset = 1'b0;
    step(WT);
    run_pass();
    chk("t6_rd_addr", last_rd_addr, 0);
    chk("t6_err_after", seq_err, 0);

    step(WT); step(WT);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
